// File: rtl/mic_sampler.sv
// mic_sampler: ADCS7476-style serial ADC reader triggered by SAMPLE_CLK rising edges.
// Define MIC_PEAK_EN to add a windowed peak detector on PEAK; otherwise PEAK is tied to 0.
module mic_sampler #(
  parameter int SCLK_DIV    = 25,
  parameter int PEAK_WINDOW = 4000
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        SAMPLE_CLK,
  input  logic        MIC_MISO,
  output logic        MIC_SCLK,
  output logic        MIC_CS_N,
  output logic [11:0] SAMPLE,
  output logic        SAMPLE_VALID,
  output logic        OVERRUN,
  output logic [11:0] PEAK
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE, QUIET} state_t;
  state_t state, state_nxt;
  logic s1, s2, hist, armed, trig, wrap, rise;
  logic [1:0] vld;
  logic [7:0] hcnt;
  logic [4:0] bcnt;
  logic [11:0] shift;
  if (SCLK_DIV < 2 || SCLK_DIV > 255 || PEAK_WINDOW < 1) begin : g_bad_param
    $error("mic_sampler: illegal parameter value");
  end
  // armed blocks a trigger from a SAMPLE_CLK already high when reset releases
  assign trig = s2 & ~hist & armed;
  assign wrap = hcnt == 8'(SCLK_DIV - 1);
  assign rise = state == SHIFT && wrap && !MIC_SCLK;
  assign MIC_CS_N = state != SHIFT;
  always_comb begin
    state_nxt = state == IDLE  ? (trig ? SHIFT : IDLE) :
                state == SHIFT ? (rise && bcnt == 5'd15 ? DONE : SHIFT) :
                state == DONE  ? QUIET :
                (wrap ? IDLE : QUIET);
  end
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      {s1, s2, hist, armed, vld} <= '0;
      hcnt <= '0;
      bcnt <= '0;
      shift <= '0;
      MIC_SCLK <= 1'b1;
      SAMPLE <= '0;
      SAMPLE_VALID <= 1'b0;
      OVERRUN <= 1'b0;
    end else begin
      s1 <= SAMPLE_CLK;
      s2 <= s1;
      hist <= s2;
      vld <= {vld[0], 1'b1};
      armed <= armed | (vld[1] & ~s2);
      SAMPLE_VALID <= state == DONE;
      if (trig && state != IDLE) OVERRUN <= 1'b1;
      hcnt <= (state == SHIFT || state == QUIET) && !wrap ? hcnt + 8'd1 : 8'd0;
      if (state == SHIFT && wrap) MIC_SCLK <= ~MIC_SCLK;
      if (state == IDLE) bcnt <= '0;
      else if (rise) bcnt <= bcnt + 5'd1;
      if (rise) shift <= {shift[10:0], MIC_MISO};
      if (state == DONE) SAMPLE <= shift;
    end
  end
`ifdef MIC_PEAK_EN
  localparam int WW = PEAK_WINDOW > 1 ? $clog2(PEAK_WINDOW) : 1;
  logic [WW-1:0] wcnt;
  logic [11:0] run_max, nxt_max;
  assign nxt_max = SAMPLE > run_max ? SAMPLE : run_max;
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      wcnt <= '0;
      run_max <= '0;
      PEAK <= '0;
    end else if (SAMPLE_VALID) begin
      if (wcnt == WW'(PEAK_WINDOW - 1)) begin
        PEAK <= nxt_max;
        run_max <= '0;
        wcnt <= '0;
      end else begin
        run_max <= nxt_max;
        wcnt <= wcnt + 1'b1;
      end
    end
  end
`else
  assign PEAK = '0;
`endif
endmodule

// File: tb/tb_mic_sampler.sv
// tb_mic_sampler: directed frame table plus overrun and mid-frame reset sequences for mic_sampler.
module tb_mic_sampler;
  localparam int D = 25;
`ifdef MIC_PEAK_EN
  localparam bit PEAK_ON = 1'b1;
`else
  localparam bit PEAK_ON = 1'b0;
`endif
  logic CLOCK = 1'b0, RESET_N = 1'b0, SAMPLE_CLK = 1'b0, MIC_MISO = 1'b0;
  logic MIC_SCLK, MIC_CS_N, SAMPLE_VALID, OVERRUN;
  logic [11:0] SAMPLE, PEAK;
  mic_sampler #(.SCLK_DIV(D), .PEAK_WINDOW(4)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .SAMPLE_CLK(SAMPLE_CLK), .MIC_MISO(MIC_MISO),
    .MIC_SCLK(MIC_SCLK), .MIC_CS_N(MIC_CS_N), .SAMPLE(SAMPLE), .SAMPLE_VALID(SAMPLE_VALID),
    .OVERRUN(OVERRUN), .PEAK(PEAK)
  );
  always #5 CLOCK = ~CLOCK;
  int cyc = 0;
  always @(posedge CLOCK) cyc <= cyc + 1;
  logic [15:0] adc_word = 16'h0000;
  int idx = 0;
  // ADC model: first bit on CS fall, following bits on each SCLK fall
  always @(negedge MIC_CS_N or negedge MIC_SCLK) begin
    if (MIC_SCLK) begin
      idx = 0;
      MIC_MISO = adc_word[15];
    end else if (idx < 16) begin
      MIC_MISO = adc_word[15 - idx];
      idx++;
    end
  end
  logic prev_cs = 1'b1, prev_sclk = 1'b1, prev_v = 1'b0;
  int cs_fall_cyc = 0, cs_rise_cyc = 0, v_cyc = 0, last_tog = 0;
  int n_cs = 0, n_fall = 0, n_rise = 0, bad_ph = 0, v_hi = 0;
  always @(negedge CLOCK) begin
    if (prev_cs && !MIC_CS_N) begin
      cs_fall_cyc = cyc;
      last_tog = cyc;
      n_cs++;
    end
    if (!prev_cs && MIC_CS_N) cs_rise_cyc = cyc;
    if (MIC_SCLK != prev_sclk) begin
      if (!MIC_SCLK) n_fall++;
      else n_rise++;
      if (cyc - last_tog != D) bad_ph++;
      last_tog = cyc;
    end
    if (SAMPLE_VALID) begin
      v_hi++;
      if (!prev_v) v_cyc = cyc;
    end
    prev_cs = MIC_CS_N;
    prev_sclk = MIC_SCLK;
    prev_v = SAMPLE_VALID;
  end
  int checks = 0, errors = 0;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(negedge CLOCK);
    #1;
  endtask
  task automatic wait_valid(input int snap_v);
    for (int i = 0; i < 3000 && v_hi == snap_v; i++) tick();
    chk("valid_timeout", int'(v_hi != snap_v), 1);
  endtask
  task automatic wait_cs(input int snap_cs);
    for (int i = 0; i < 50 && n_cs == snap_cs; i++) tick();
    chk("cs_timeout", int'(n_cs != snap_cs), 1);
  endtask
  task automatic run_frame(input logic [15:0] w, input logic [11:0] smp, input logic [11:0] pk);
    int sv, sf, sr, sb, sc;
    adc_word = w;
    sv = v_hi; sf = n_fall; sr = n_rise; sb = bad_ph; sc = n_cs;
    SAMPLE_CLK = 1'b1;
    wait_valid(sv);
    repeat (40) tick();
    chk("sample", int'(SAMPLE), int'(smp));
    chk("valid_width", v_hi - sv, 1);
    chk("frames", n_cs - sc, 1);
    chk("latency", v_cyc - cs_fall_cyc, 32 * D + 1);
    chk("cs_low", cs_rise_cyc - cs_fall_cyc, 32 * D);
    chk("sclk_falls", n_fall - sf, 16);
    chk("sclk_rises", n_rise - sr, 16);
    chk("sclk_phase", bad_ph - sb, 0);
    chk("overrun", int'(OVERRUN), 0);
    chk("peak", int'(PEAK), PEAK_ON ? int'(pk) : 0);
    SAMPLE_CLK = 1'b0;
    repeat (5) tick();
  endtask
  typedef struct {
    logic [15:0] word;
    logic [11:0] smp;
    logic [11:0] pk;
  } vec_t;
  vec_t tbl[10];
  initial begin
    int sv, sc;
    tbl[0] = '{16'h0100, 12'h100, 12'h000};
    tbl[1] = '{16'h0FFF, 12'hFFF, 12'h000};
    tbl[2] = '{16'hF200, 12'h200, 12'h000};
    tbl[3] = '{16'h0050, 12'h050, 12'hFFF};
    tbl[4] = '{16'h0010, 12'h010, 12'hFFF};
    tbl[5] = '{16'hA010, 12'h010, 12'hFFF};
    tbl[6] = '{16'h0010, 12'h010, 12'hFFF};
    tbl[7] = '{16'h0010, 12'h010, 12'h010};
    tbl[8] = '{16'hF123, 12'h123, 12'h010};
    tbl[9] = '{16'h0A5C, 12'hA5C, 12'h010};
    repeat (3) tick();
    chk("rst_cs_n", int'(MIC_CS_N), 1);
    chk("rst_sclk", int'(MIC_SCLK), 1);
    chk("rst_sample", int'(SAMPLE), 0);
    chk("rst_valid", int'(SAMPLE_VALID), 0);
    chk("rst_overrun", int'(OVERRUN), 0);
    chk("rst_peak", int'(PEAK), 0);
    RESET_N = 1'b1;
    repeat (10) tick();
    foreach (tbl[i]) run_frame(tbl[i].word, tbl[i].smp, tbl[i].pk);
    adc_word = 16'h0333;
    sv = v_hi; sc = n_cs;
    SAMPLE_CLK = 1'b1;
    wait_cs(sc);
    repeat (200) tick();
    SAMPLE_CLK = 1'b0;
    repeat (200) tick();
    SAMPLE_CLK = 1'b1;
    wait_valid(sv);
    repeat (100) tick();
    chk("ovr_flag", int'(OVERRUN), 1);
    chk("ovr_frames", n_cs - sc, 1);
    chk("ovr_sample", int'(SAMPLE), 12'h333);
    chk("ovr_valid_width", v_hi - sv, 1);
    SAMPLE_CLK = 1'b0;
    repeat (10) tick();
    adc_word = 16'h0777;
    sc = n_cs;
    SAMPLE_CLK = 1'b1;
    wait_cs(sc);
    repeat (200) tick();
    #2;
    RESET_N = 1'b0;
    #1;
    sv = v_hi; sc = n_cs;
    chk("mid_rst_cs_n", int'(MIC_CS_N), 1);
    chk("mid_rst_sclk", int'(MIC_SCLK), 1);
    chk("mid_rst_sample", int'(SAMPLE), 0);
    chk("mid_rst_valid", int'(SAMPLE_VALID), 0);
    chk("mid_rst_overrun", int'(OVERRUN), 0);
    chk("mid_rst_peak", int'(PEAK), 0);
    tick();
    RESET_N = 1'b1;
    repeat (60) tick();
    chk("mid_rst_no_frame", n_cs - sc, 0);
    chk("mid_rst_no_valid", v_hi - sv, 0);
    SAMPLE_CLK = 1'b0;
    repeat (5) tick();
    run_frame(16'h0ABC, 12'hABC, 12'h000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
